jk_excitation_driver: RTL

- Inverse of a JK flip-flop bank: accepts a target word, reads back the bank's current Q, and drives J/K so the bank reaches the target in one clock.
- Sits between a control sequencer (valid/ready target port) and a WIDTH-bit bank of JKFFasync instances sharing the same CLK/RESET_N.
- Replaces hand-written J/K stimulus with a synthesizable driver that can optionally verify the result.

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_excite_bit.sv | 27 ++
 rtl/jk_excitation_driver.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types and {J,K} excitation constants for the JK excitation driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        APPLY  = 2'b01,
        SETTLE = 2'b10,
        CHECK  = 2'b11
    } jk_state_e;

    // Bit order is {J,K}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit inverse JK table: picks the {J,K} pair that moves q to target in one edge.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic i_q,
    input  logic i_tgt,
    input  logic i_use_toggle,
    output logic o_j,
    output logic o_k
);

    logic [1:0] w_jk;

    // Changed bits use set/reset or toggle; unchanged bits hold.
    always_comb begin
        w_jk = JK_HOLD;
        case ({i_q, i_tgt})
            2'b01:   w_jk = i_use_toggle ? JK_TOGGLE : JK_SET;
            2'b10:   w_jk = i_use_toggle ? JK_TOGGLE : JK_RESET;
            default: w_jk = JK_HOLD;
        endcase
    end

    assign o_j = w_jk[1];
    assign o_k = w_jk[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to a requested target word in one clock.
// Optional readback check with retries: define JK_READBACK_CHECK_EN.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit USE_TOGGLE = 1'b0,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_RETRY  = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TGT_VALID,
    output logic             TGT_READY,
    input  logic [WIDTH-1:0] TGT_DATA,
    input  logic [WIDTH-1:0] Q_IN,
    output logic [WIDTH-1:0] J_OUT,
    output logic [WIDTH-1:0] K_OUT,
    output logic             DONE,
    output logic             ERR
);

    localparam int SC = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int SW = (SC > 1) ? $clog2(SC) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SC - 1);

    jk_state_e        r_state;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_ready;
    logic [SW-1:0]    r_settle_cnt;
    logic [WIDTH-1:0] w_tgt_sel;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

`ifdef JK_READBACK_CHECK_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    logic [RW-1:0] r_retry;
    logic          r_err;
`endif

    // At acceptance the fresh target is encoded; on a retry the latched one is.
    always_comb begin
        if (r_state == IDLE) begin
            w_tgt_sel = TGT_DATA;
        end else begin
            w_tgt_sel = r_tgt;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_excite_bit u_bit (
            .i_q          (Q_IN[gi]),
            .i_tgt        (w_tgt_sel[gi]),
            .i_use_toggle (USE_TOGGLE),
            .o_j          (w_j[gi]),
            .o_k          (w_k[gi])
        );
    end

    // Transaction FSM with registered handshake and excitation outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_tgt        <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_done       <= 1'b0;
            r_ready      <= 1'b0;
            r_settle_cnt <= '0;
`ifdef JK_READBACK_CHECK_EN
            r_retry      <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    r_j     <= '0;
                    r_k     <= '0;
                    if (TGT_VALID && r_ready) begin
                        r_tgt   <= TGT_DATA;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_ready <= 1'b0;
                        r_state <= APPLY;
`ifdef JK_READBACK_CHECK_EN
                        r_retry <= '0;
                        r_err   <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    r_j          <= '0;
                    r_k          <= '0;
                    r_settle_cnt <= SETTLE_LOAD;
                    r_state      <= SETTLE;
                end
                SETTLE: begin
                    if (r_settle_cnt == '0) begin
`ifdef JK_READBACK_CHECK_EN
                        r_state <= CHECK;
`else
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
`endif
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                CHECK: begin
`ifdef JK_READBACK_CHECK_EN
                    if (Q_IN == r_tgt) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else if (r_retry < RETRY_LIMIT) begin
                        // Re-excite from what the bank actually holds now
                        r_retry <= r_retry + 1'b1;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= APPLY;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end
`else
                    r_state <= IDLE;
                    r_ready <= 1'b1;
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign TGT_READY = r_ready;
    assign J_OUT     = r_j;
    assign K_OUT     = r_k;
    assign DONE      = r_done;
`ifdef JK_READBACK_CHECK_EN
    assign ERR       = r_err;
`else
    assign ERR       = 1'b0;
`endif

endmodule
